axi_lite_master_engine: RTL



---
 rtl/axi_lite_master_engine_pkg.sv | 40 ++++
 rtl/axi_lite_master_engine_if.sv | 89 ++++++++
 rtl/axi_lite_master_engine_wdog.sv | 31 +++
 rtl/axi_lite_master_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_master_engine_pkg.sv
// Shared types for the AXI4-Lite master engine.
// Response codes, engine states and command/response bundles.
package axi_lite_pkg;

  localparam int PROT_W = 3;
  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD,
    S_RDATA,
    S_DRAIN,
    S_RSP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [PROT_W-1:0] prot;
  } cmd_t;

  typedef struct packed {
    logic  write;
    resp_t resp;
    logic  timeout;
  } rsp_t;

  function automatic logic is_err(input logic [RESP_W-1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi_lite_master_engine_if.sv
// Command/response stream and AXI4-Lite bus interfaces
// for the master engine.
interface axi_lite_cmd_if #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32
);
  localparam int SSIZE = DSIZE / 8;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [ASIZE-1:0] cmd_addr;
  logic [DSIZE-1:0] cmd_wdata;
  logic [SSIZE-1:0] cmd_wstrb;
  logic [2:0]       cmd_prot;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [DSIZE-1:0] rsp_rdata;
  logic [1:0]       rsp_resp;
  logic             rsp_timeout;

  modport master (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_wstrb, cmd_prot,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_write,
    input  rsp_rdata, rsp_resp, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_wstrb, cmd_prot,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_write,
    output rsp_rdata, rsp_resp, rsp_timeout
  );
endinterface

interface axi_lite_if #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32
);
  localparam int SSIZE = DSIZE / 8;

  logic             awvalid;
  logic             awready;
  logic [ASIZE-1:0] awaddr;
  logic [2:0]       awprot;
  logic             wvalid;
  logic             wready;
  logic [DSIZE-1:0] wdata;
  logic [SSIZE-1:0] wstrb;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [ASIZE-1:0] araddr;
  logic [2:0]       arprot;
  logic             rvalid;
  logic             rready;
  logic [DSIZE-1:0] rdata;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_master_engine_wdog.sv
// Per-transaction watchdog: saturating counter,
// cleared on command accept; TIMEOUT = 0 disables it.
module axi_lite_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite master: one command in, one AXI transaction,
// one response out, with timeout and sticky error flag.
module axi_lite_master_engine
  import axi_lite_pkg::*;
#(
  parameter int ASIZE   = 8,
  parameter int DSIZE   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           axi_lite_aclk,
  input  logic           axi_lite_resetn,
  axi_lite_cmd_if.slave  cmd,
  axi_lite_if.master     axi,
  output logic           busy,
  output logic           err_sticky
);

  localparam int SSIZE = DSIZE / 8;

  state_t           r_state;
  logic             r_awvalid;
  logic             r_wvalid;
  logic             r_arvalid;
  logic [ASIZE-1:0] r_addr;
  logic [2:0]       r_prot;
  logic [DSIZE-1:0] r_wdata;
  logic [SSIZE-1:0] r_wstrb;
  rsp_t             r_rsp;
  logic [DSIZE-1:0] r_rdata;
  logic             r_rsp_valid;
  logic             r_err;
  logic             r_drop_b;
  logic             r_drop_r;

  cmd_t w_cmd;
  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rsp_hs;
  logic w_aw_left;
  logic w_w_left;
  logic w_ar_left;
  logic w_bready;
  logic w_rready;
  logic w_wd_en;
  logic w_expired;

  axi_lite_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (axi_lite_aclk),
    .rst_n     (axi_lite_resetn),
    .i_clr     (w_cmd_hs),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_cmd.write = cmd.cmd_write;
    w_cmd.prot  = cmd.cmd_prot;
    // a timed-out response is still owed; keep ready up to absorb it
    w_bready  = r_drop_b || r_state == S_WRESP
             || r_state == S_DRAIN;
    w_rready  = r_drop_r || r_state == S_RDATA
             || r_state == S_DRAIN;
    w_cmd_hs  = cmd.cmd_valid && r_state == S_IDLE;
    w_aw_hs   = r_awvalid && axi.awready;
    w_w_hs    = r_wvalid && axi.wready;
    w_b_hs    = axi.bvalid && w_bready;
    w_ar_hs   = r_arvalid && axi.arready;
    w_r_hs    = axi.rvalid && w_rready;
    w_rsp_hs  = r_rsp_valid && cmd.rsp_ready;
    w_aw_left = r_awvalid && !axi.awready;
    w_w_left  = r_wvalid && !axi.wready;
    w_ar_left = r_arvalid && !axi.arready;
    w_wd_en   = r_state == S_WR || r_state == S_WRESP
             || r_state == S_RD || r_state == S_RDATA;

    cmd.cmd_ready   = r_state == S_IDLE && axi_lite_resetn;
    cmd.rsp_valid   = r_rsp_valid;
    cmd.rsp_write   = r_rsp.write;
    cmd.rsp_rdata   = r_rdata;
    cmd.rsp_resp    = r_rsp.resp;
    cmd.rsp_timeout = r_rsp.timeout;

    axi.awvalid = r_awvalid;
    axi.awaddr  = r_addr;
    axi.awprot  = r_prot;
    axi.wvalid  = r_wvalid;
    axi.wdata   = r_wdata;
    axi.wstrb   = r_wstrb;
    axi.bready  = w_bready;
    axi.arvalid = r_arvalid;
    axi.araddr  = r_addr;
    axi.arprot  = r_prot;
    axi.rready  = w_rready;

    busy       = r_state != S_IDLE;
    err_sticky = r_err;
  end

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_resetn) begin
    if (!axi_lite_resetn) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_addr      <= '0;
      r_prot      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp       <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_drop_b    <= 1'b0;
      r_drop_r    <= 1'b0;
    end else begin
      if (w_b_hs && r_drop_b) r_drop_b <= 1'b0;
      if (w_r_hs && r_drop_r) r_drop_r <= 1'b0;
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      if (w_ar_hs) r_arvalid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_addr        <= cmd.cmd_addr;
            r_prot        <= w_cmd.prot;
            r_wdata       <= cmd.cmd_wdata;
            r_wstrb       <= cmd.cmd_wstrb;
            r_rsp.write   <= w_cmd.write;
            r_rsp.resp    <= OKAY;
            r_rsp.timeout <= 1'b0;
            r_rdata       <= '0;
            if (w_cmd.write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD;
            end
          end
        end
        S_WR: begin
          if (!w_aw_left && !w_w_left) begin
            r_state <= S_WRESP;
          end else if (w_expired) begin
            r_rsp.resp    <= DECERR;
            r_rsp.timeout <= 1'b1;
            r_err         <= 1'b1;
            r_drop_b      <= 1'b1;
            r_state       <= S_DRAIN;
          end
        end
        S_WRESP: begin
          if (w_b_hs && !r_drop_b) begin
            r_rsp.resp  <= resp_t'(axi.bresp);
            r_err       <= r_err | is_err(axi.bresp);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_expired) begin
            r_rsp.resp    <= DECERR;
            r_rsp.timeout <= 1'b1;
            r_err         <= 1'b1;
            r_drop_b      <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RD: begin
          if (!w_ar_left) begin
            r_state <= S_RDATA;
          end else if (w_expired) begin
            r_rsp.resp    <= DECERR;
            r_rsp.timeout <= 1'b1;
            r_err         <= 1'b1;
            r_drop_r      <= 1'b1;
            r_state       <= S_DRAIN;
          end
        end
        S_RDATA: begin
          if (w_r_hs && !r_drop_r) begin
            r_rdata     <= axi.rdata;
            r_rsp.resp  <= resp_t'(axi.rresp);
            r_err       <= r_err | is_err(axi.rresp);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_expired) begin
            r_rdata       <= '0;
            r_rsp.resp    <= DECERR;
            r_rsp.timeout <= 1'b1;
            r_err         <= 1'b1;
            r_drop_r      <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_DRAIN: begin
          if (!w_aw_left && !w_w_left && !w_ar_left) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
